// File: rtl/logo_bounce_gen.sv
// Pixel-colour stage: draws a 4-tile bouncing logo and re-times syncs to match registered RGB.
// Latency: RGB and syncs for a pixel appear one pix_clk enable after pix_x/pix_y/syncs are presented.
// Backpressure: none; the stage follows the timing generator and updates only on pix_clk cycles.
module logo_bounce_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X0       = 255,
    parameter int Y0       = 40,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_clk,
    input  logic       enable,
    input  logic [9:0] pix_x,
    input  logic [8:0] pix_y,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic       r_out,
    output logic       g_out,
    output logic       b_out,
    output logic       h_sync,
    output logic       v_sync
);

    localparam int LOGO_W   = 130;
    localparam int TILE_W   = 50;
    localparam int TILE_OFF = 80;

    typedef enum logic [1:0] {C0, C1, C2, C3} cstate_t;

    // Motion / colour state. dir bit: 0 = right/down, 1 = left/up.
    logic [9:0] org_x_q, org_x_d;
    logic [9:0] org_y_q, org_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    cstate_t    cstate_q, cstate_d;
    logic       vs_prev_q;

    logic        bounce_x, bounce_y;
    logic        frame_tick;
    logic [10:0] sum_x, sum_y;

    // Pixel path
    logic [9:0] pix_y_w;
    logic [9:0] rx, ry;
    logic       in_x, in_y;
    logic       col0, col1, row0, row1;
    logic       lit, blank;
    logic [1:0] tile_id, pal_idx;
    logic [2:0] rgb_d;

    assign frame_tick = vs_prev_q && !v_sync_in;

    // Right/down bound is checked on the would-be right/bottom edge in 11 bits so it never wraps.
    assign sum_x = {1'b0, org_x_q} + 11'(STEP) + 11'(LOGO_W);
    assign sum_y = {1'b0, org_y_q} + 11'(STEP) + 11'(LOGO_W);

    // Next origin and direction for each axis; clamped to the edge on a bounce.
    always_comb begin
        org_x_d  = org_x_q;
        dir_x_d  = dir_x_q;
        bounce_x = 1'b0;
        if (!dir_x_q) begin
            if (sum_x > 11'(H_ACTIVE)) begin
                org_x_d  = 10'(H_ACTIVE - LOGO_W);
                dir_x_d  = 1'b1;
                bounce_x = 1'b1;
            end else begin
                org_x_d = org_x_q + 10'(STEP);
            end
        end else if (org_x_q < 10'(STEP)) begin
            org_x_d  = 10'd0;
            dir_x_d  = 1'b0;
            bounce_x = 1'b1;
        end else begin
            org_x_d = org_x_q - 10'(STEP);
        end

        org_y_d  = org_y_q;
        dir_y_d  = dir_y_q;
        bounce_y = 1'b0;
        if (!dir_y_q) begin
            if (sum_y > 11'(V_ACTIVE)) begin
                org_y_d  = 10'(V_ACTIVE - LOGO_W);
                dir_y_d  = 1'b1;
                bounce_y = 1'b1;
            end else begin
                org_y_d = org_y_q + 10'(STEP);
            end
        end else if (org_y_q < 10'(STEP)) begin
            org_y_d  = 10'd0;
            dir_y_d  = 1'b0;
            bounce_y = 1'b1;
        end else begin
            org_y_d = org_y_q - 10'(STEP);
        end

        // A corner hit still advances the palette only once.
        cstate_d = (bounce_x || bounce_y) ? cstate_t'(cstate_q + 2'd1) : cstate_q;
    end

    // Origin/colour FSM: moves only on a vsync falling edge, which lands inside vertical blank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            org_x_q   <= 10'(X0);
            org_y_q   <= 10'(Y0);
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            cstate_q  <= C0;
            vs_prev_q <= 1'b1;
        end else if (pix_clk) begin
            vs_prev_q <= v_sync_in;
            if (frame_tick && enable) begin
                org_x_q  <= org_x_d;
                org_y_q  <= org_y_d;
                dir_x_q  <= dir_x_d;
                dir_y_q  <= dir_y_d;
                cstate_q <= cstate_d;
            end
        end
    end

    // Tile hit test relative to the origin; interiors are strict so tile borders stay dark.
    assign pix_y_w = {1'b0, pix_y};
    assign rx      = pix_x - org_x_q;
    assign ry      = pix_y_w - org_y_q;
    assign in_x    = pix_x >= org_x_q;
    assign in_y    = pix_y_w >= org_y_q;
    assign col0    = in_x && (rx > 10'd0) && (rx < 10'(TILE_W));
    assign col1    = in_x && (rx > 10'(TILE_OFF)) && (rx < 10'(TILE_OFF + TILE_W));
    assign row0    = in_y && (ry > 10'd0) && (ry < 10'(TILE_W));
    assign row1    = in_y && (ry > 10'(TILE_OFF)) && (ry < 10'(TILE_OFF + TILE_W));
    assign lit     = (col0 || col1) && (row0 || row1);
    assign blank   = (pix_x >= 10'(H_ACTIVE)) || (pix_y_w >= 10'(V_ACTIVE));
    assign tile_id = {row1, col1};
    assign pal_idx = tile_id + cstate_q;

    // Palette lookup with blanking override.
    always_comb begin
        rgb_d = 3'b000;
        if (lit && !blank) begin
            case (pal_idx)
                2'd0:    rgb_d = 3'b100;
                2'd1:    rgb_d = 3'b010;
                2'd2:    rgb_d = 3'b001;
                default: rgb_d = 3'b110;
            endcase
        end
    end

    // Output register: colour and syncs share one pixel of delay so they stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= 1'b0;
            g_out  <= 1'b0;
            b_out  <= 1'b0;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
        end else if (pix_clk) begin
            {r_out, g_out, b_out} <= rgb_d;
            h_sync <= h_sync_in;
            v_sync <= v_sync_in;
        end
    end

endmodule

// File: tb/tb_logo_bounce_gen.sv
module tb_logo_bounce_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_clk;
    logic       enable;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       hs_in, vs_in;
    logic       r, g, b, hs, vs;
    logic       r2, g2, b2, hs2, vs2;

    always #5 clk = ~clk;

    logo_bounce_gen dut (
        .clk(clk), .rst(rst), .pix_clk(pix_clk), .enable(enable),
        .pix_x(pix_x), .pix_y(pix_y), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .r_out(r), .g_out(g), .b_out(b), .h_sync(hs), .v_sync(vs)
    );

    // Second instance starts in the bottom-right corner heading right/down.
    logo_bounce_gen #(.X0(510), .Y0(350)) dut2 (
        .clk(clk), .rst(rst), .pix_clk(pix_clk), .enable(enable),
        .pix_x(pix_x), .pix_y(pix_y), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .r_out(r2), .g_out(g2), .b_out(b2), .h_sync(hs2), .v_sync(vs2)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of the primary instance
    int m_x, m_y, m_dx, m_dy, m_c;
    bit m_vsp;

    logic [2:0] exp_rgb;
    logic       exp_hs, exp_vs;
    event       cmp_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] pal(input int i);
        case (i)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic [2:0] model_rgb(input int x, input int y);
        if (x >= 640 || y >= 480) return 3'b000;
        for (int t = 0; t < 4; t++) begin
            int lx, ty;
            lx = m_x + 80 * (t % 2);
            ty = m_y + 80 * (t / 2);
            if (x > lx && x < lx + 50 && y > ty && y < ty + 50)
                return pal((t + m_c) % 4);
        end
        return 3'b000;
    endfunction

    task automatic model_axis(inout int p, inout int d, input int lim, output bit bnc);
        bnc = 1'b0;
        if (d > 0) begin
            if (p + 2 + 130 > lim) begin p = lim - 130; d = -1; bnc = 1'b1; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; d = 1; bnc = 1'b1; end
            else p = p - 2;
        end
    endtask

    task automatic model_reset();
        m_x = 255; m_y = 40; m_dx = 1; m_dy = 1; m_c = 0; m_vsp = 1'b1;
    endtask

    // Present one pixel for one pix_clk enable; expectations come from the model state before any tick.
    task automatic pix(input int x, input int y, input logic h, input logic v);
        bit bx, by;
        @(negedge clk);
        pix_x = 10'(x); pix_y = 9'(y); hs_in = h; vs_in = v; pix_clk = 1'b1;
        exp_rgb = model_rgb(x, y);
        exp_hs  = h;
        exp_vs  = v;
        if (m_vsp && !v && enable) begin
            model_axis(m_x, m_dx, 640, bx);
            model_axis(m_y, m_dy, 480, by);
            if (bx || by) m_c = (m_c + 1) % 4;
        end
        m_vsp = v;
        @(negedge clk);
        pix_clk = 1'b0;
        -> cmp_ev;
    endtask

    task automatic tick();
        pix(700, 500, 1'b1, 1'b1);
        pix(700, 500, 1'b1, 1'b0);
    endtask

    // Every presented pixel: outputs must match the model.
    always @(cmp_ev) begin
        check("rgb", {29'd0, r, g, b}, {29'd0, exp_rgb});
        check("hsync", {31'd0, hs}, {31'd0, exp_hs});
        check("vsync", {31'd0, vs}, {31'd0, exp_vs});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sx, sy;
        rst = 1'b0; pix_clk = 1'b0; enable = 1'b0;
        pix_x = '0; pix_y = '0; hs_in = 1'b1; vs_in = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rgb", {29'd0, r, g, b}, 32'd0);
        check("rst_hs", {31'd0, hs}, 32'd1);
        check("rst_vs", {31'd0, vs}, 32'd1);
        check("rst_orgx", 32'(dut.org_x_q), 32'd255);
        check("rst_orgy", 32'(dut.org_y_q), 32'd40);
        rst = 1'b1;

        // Frozen frame at the reset origin
        tick();
        pix(280, 65, 1'b1, 1'b1);  check("t1_tl", {29'd0, r, g, b}, 32'b100);
        pix(360, 65, 1'b1, 1'b1);  check("t1_tr", {29'd0, r, g, b}, 32'b010);
        pix(280, 145, 1'b1, 1'b1); check("t1_bl", {29'd0, r, g, b}, 32'b001);
        pix(360, 145, 1'b1, 1'b1); check("t1_br", {29'd0, r, g, b}, 32'b110);
        pix(255, 65, 1'b1, 1'b1);  check("t1_edge", {29'd0, r, g, b}, 32'b000);
        check("t1_hold_x", 32'(dut.org_x_q), 32'd255);

        // One moving tick
        enable = 1'b1;
        tick();
        check("t2_orgx", 32'(dut.org_x_q), 32'd257);
        check("t2_orgy", 32'(dut.org_y_q), 32'd42);
        pix(257, 43, 1'b1, 1'b1); check("t2_border", {29'd0, r, g, b}, 32'b000);
        pix(258, 43, 1'b1, 1'b1); check("t2_first", {29'd0, r, g, b}, 32'b100);
        pix(259, 44, 1'b1, 1'b1); check("t2_in", {29'd0, r, g, b}, 32'b100);

        // Corner bounce on the second instance: origin pinned, colour advances once
        check("t4_orgx", 32'(dut2.org_x_q), 32'd510);
        check("t4_orgy", 32'(dut2.org_y_q), 32'd350);
        check("t4_cst", 32'(dut2.cstate_q), 32'd1);
        pix(520, 360, 1'b1, 1'b1); check("t4_tl", {29'd0, r2, g2, b2}, 32'b010);

        // Walk right to the bounce
        for (int i = 0; i < 126; i++) begin
            tick();
            check("walk_x", 32'(dut.org_x_q), 32'(m_x));
            check("walk_y", 32'(dut.org_y_q), 32'(m_y));
            if (i == 0) begin
                check("t4_next_x", 32'(dut2.org_x_q), 32'd508);
                check("t4_next_y", 32'(dut2.org_y_q), 32'd348);
                check("t4_next_c", 32'(dut2.cstate_q), 32'd1);
            end
        end
        check("t3_pre", 32'(dut.org_x_q), 32'd509);
        tick();
        check("t3_orgx", 32'(dut.org_x_q), 32'd510);
        check("t3_cst", 32'(dut.cstate_q), 32'd1);
        pix(520, m_y + 10, 1'b1, 1'b1); check("t3_tl", {29'd0, r, g, b}, 32'b010);
        tick();
        check("t3_left", 32'(dut.org_x_q), 32'd508);

        // Long run with probes around the logo
        for (int i = 0; i < 320; i++) begin
            tick();
            pix(m_x + (i * 7) % 140, m_y + (i * 13) % 140, 1'(i % 2), 1'b1);
            check("run_x", 32'(dut.org_x_q), 32'(m_x));
            check("run_y", 32'(dut.org_y_q), 32'(m_y));
            check("run_c", 32'(dut.cstate_q), 32'(m_c));
        end

        // Disabled: ticks ignored
        enable = 1'b0;
        sx = m_x; sy = m_y;
        repeat (3) tick();
        check("dis_x", 32'(dut.org_x_q), 32'(sx));
        check("dis_y", 32'(dut.org_y_q), 32'(sy));

        // Blanking and sync alignment
        pix(700, 100, 1'b1, 1'b1); check("t5_hblank", {29'd0, r, g, b}, 32'b000);
        pix(300, 490, 1'b1, 1'b1); check("t5_vblank", {29'd0, r, g, b}, 32'b000);
        pix(300, 100, 1'b0, 1'b1); check("t5_hs_fall", {31'd0, hs}, 32'd0);
        pix(300, 100, 1'b1, 1'b0); check("t5_hs_rise", {31'd0, hs}, 32'd1);
        check("t5_vs_fall", {31'd0, vs}, 32'd0);
        pix(300, 100, 1'b1, 1'b1); check("t5_vs_rise", {31'd0, vs}, 32'd1);

        // Asynchronous reset mid-line
        pix(m_x + 10, m_y + 10, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        check("t6_rgb", {29'd0, r, g, b}, 32'd0);
        check("t6_hs", {31'd0, hs}, 32'd1);
        check("t6_vs", {31'd0, vs}, 32'd1);
        check("t6_orgx", 32'(dut.org_x_q), 32'd255);
        check("t6_orgy", 32'(dut.org_y_q), 32'd40);
        @(negedge clk);
        rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        model_reset();
        pix(280, 65, 1'b1, 1'b1); check("t6_after", {29'd0, r, g, b}, 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
